inst_queue: RTL and testbench
=============================

// Module: inst_queue
// PURPOSE
//  Decoupling FIFO between fetch and decode. Each cycle it accepts a fetch bundle of up to 4 slots
//  (pc, inst, branch prediction) and presents the oldest 4 queued slots to decode in program order.
//  Fetch retires up to 4 slots per cycle; decode consumes 0-4 per cycle.
//  Flush discards everything on a redirect or mispredict.
//  Backpressure goes to fetch through stall.
// PARAMETERS
//  DEPTH  16  queue entries, one slot each; power of 2, >= 8
// PORTS
//  clk             in   1         clock; all state updates on posedge
//  rst             in   1         synchronous reset, active-high
//  flush           in   1         discard all entries (synchronous)
//  in_count        in   3         valid slots in fetch bundle, 0..4; slots 0..in_count-1 valid
//  in_pc[4]        in   32 each   slot pc
//  in_inst[4]      in   32 each   slot instruction word
//  in_pred_taken[4] in  1 each    predicted taken
//  in_pred_addr[4] in   32 each   predicted target (RAS top already applied by fetch)
//  stall           out  1         queue cannot take a full bundle; fetch holds its pc
//  out_valid[4]    out  1 each    out_valid[i] = (i < count); always a contiguous prefix
//  out_pc/out_inst/out_pred_taken/out_pred_addr[4]  out  as inputs  entry at head+i
//  deq_num         in   3         slots consumed by decode this cycle, 0..4
//  count           out  log2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  State:
//  - Storage array of DEPTH entries; data is not reset.
//  - head and tail pointers, log2(DEPTH) bits each, wrap modulo DEPTH.
//  - count register.
//  Reset:
//  - head, tail and count are set to 0.
//  - Outputs after reset: stall=0, out_valid=0000, all out_* data fields driven 0.
//  stall:
//  - stall = (count > DEPTH-4). It is a function of the registered count only.
//  - It does not account for a same-cycle dequeue (conservative).
//  Enqueue:
//  - enq = (!stall && !flush) ? in_count : 0.
//  - Slot i is written at tail+i, for i < enq.
//  - tail advances by enq.
//  - A bundle offered while stall=1 is dropped silently. Fetch re-presents it, since its pc is frozen by stall.
//  Dequeue:
//  - deq = min(deq_num, count). The RTL clamps the value.
//  - The bench flags deq_num > count as a protocol error.
//  - head advances by deq.
//  - Decode may consume only a prefix of the valid slots.
//  Output data:
//  - out_* for slot i is a combinational read of the entry at (head+i) mod DEPTH.
//  - It is forced to 0 when out_valid[i]=0.
//  Count update:
//  - count_next = count + enq - deq, computed at log2(DEPTH)+1 bits.
//  - Simultaneous enqueue and dequeue are both honoured in the same cycle.
//  Latency:
//  - A slot accepted in cycle t is visible on out_* in cycle t+1.
//  - There is no fetch-to-decode bypass.
//  - FIFO order is strict; slot i of a bundle precedes slot i+1.
//  Flush:
//  - Next cycle: head=tail=0, count=0.
//  - Flush overrides any same-cycle enqueue and dequeue.
//  - Stored data is left as is; it is masked by out_valid.
//  Reset or flush mid-stream:
//  - No partial bundle survives.
//  - A bundle straddling the wrap point is written across the array end and read back in order.
//  Invariant: 0 <= count <= DEPTH. Overflow is impossible because stall reserves 4 free entries.
// TESTING
//  1 Reset:
//    - rst=1 for 2 cycles -> count=0, stall=0, out_valid=0000, out_pc[0..3]=0.
//  2 Partial bundle:
//    - in_count=2, in_pc[0]=0xBFC00000, deq_num=0.
//    - Next cycle: out_valid=0011, out_pc[1]=0xBFC00004, count=2.
//  3 Fill to full (DEPTH=16, deq_num=0):
//    - Offer four 4-slot bundles -> count=16, stall=1.
//    - A fifth bundle, pc 0x2040, is dropped; count stays 16 and pc 0x2040 is never seen on out.
//  4 Wrap and order:
//    - Stream pcs 0x1000 upward, 4 per cycle, with deq_num=4 each cycle for 12 cycles.
//    - out_pc[0] steps by 0x10 each cycle with no gaps; pointers wrap; count stays 4.
//  5 Mixed rates:
//    - count=5; in_count=3 and deq_num=2 -> count=6.
//    - Then deq_num=4 with count=2 and in_count=0 -> count=0, protocol error flagged.
//  6 Flush priority:
//    - count=9; flush=1 together with in_count=4 and deq_num=3.
//    - Next cycle: count=0, out_valid=0000, stall=0, and none of the 4 offered slots ever appear.

Source files
------------

// File: rtl/inst_queue_if.sv
// Fetch/decode interface of the instruction queue.
// The master is the fetch/decode side. The slave is the queue itself.
interface inst_queue_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic [2:0]    in_count;
  logic [31:0]   in_pc         [4];
  logic [31:0]   in_inst       [4];
  logic          in_pred_taken [4];
  logic [31:0]   in_pred_addr  [4];
  logic          stall;
  logic          out_valid     [4];
  logic [31:0]   out_pc        [4];
  logic [31:0]   out_inst      [4];
  logic          out_pred_taken[4];
  logic [31:0]   out_pred_addr [4];
  logic [2:0]    deq_num;
  logic [CW-1:0] count;

  modport master (
    output flush, in_count, in_pc, in_inst, in_pred_taken, in_pred_addr, deq_num,
    input  stall, out_valid, out_pc, out_inst, out_pred_taken, out_pred_addr, count
  );

  modport slave (
    input  flush, in_count, in_pc, in_inst, in_pred_taken, in_pred_addr, deq_num,
    output stall, out_valid, out_pc, out_inst, out_pred_taken, out_pred_addr, count
  );
endinterface

// File: rtl/inst_queue.sv
// Decoupling FIFO between fetch and decode.
// It takes up to 4 slots in per cycle and presents the oldest 4 slots in program order.
module inst_queue #(
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  inst_queue_if.slave   q
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   inst_mem  [DEPTH];
  logic          taken_mem [DEPTH];
  logic [31:0]   addr_mem  [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          stall_c;
  logic [2:0]    enq_c;
  logic [2:0]    deq_c;

  // Stall keeps 4 entries free, so a full bundle can always be written.
  always_comb begin
    stall_c = count > CW'(DEPTH - 4);
    enq_c   = (!stall_c && !q.flush) ? q.in_count : 3'd0;
    deq_c   = (CW'(q.deq_num) > count) ? 3'(count) : q.deq_num;
  end

  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_c);
      tail  <= tail + PW'(enq_c);
      count <= count + CW'(enq_c) - CW'(deq_c);
    end
  end

  // Storage is not reset. Slots past count are masked on the read side.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < enq_c) begin
          pc_mem   [tail + PW'(i)] <= q.in_pc[i];
          inst_mem [tail + PW'(i)] <= q.in_inst[i];
          taken_mem[tail + PW'(i)] <= q.in_pred_taken[i];
          addr_mem [tail + PW'(i)] <= q.in_pred_addr[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      q.out_valid[i]      = CW'(i) < count;
      q.out_pc[i]         = '0;
      q.out_inst[i]       = '0;
      q.out_pred_taken[i] = 1'b0;
      q.out_pred_addr[i]  = '0;
      if (q.out_valid[i]) begin
        q.out_pc[i]         = pc_mem   [head + PW'(i)];
        q.out_inst[i]       = inst_mem [head + PW'(i)];
        q.out_pred_taken[i] = taken_mem[head + PW'(i)];
        q.out_pred_addr[i]  = addr_mem [head + PW'(i)];
      end
    end
  end

  assign q.stall = stall_c;
  assign q.count = count;
endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue with DEPTH=16.
module tb_inst_queue;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  inst_queue_if #(.DEPTH(16)) q ();
  inst_queue #(.DEPTH(16)) dut (.clk(clk), .rst(rst), .q(q));

  always #5 clk = ~clk;

  function automatic logic [3:0] vld();
    return {q.out_valid[3], q.out_valid[2], q.out_valid[1], q.out_valid[0]};
  endfunction

  // Advance one clock edge. Outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input logic [31:0] base, input int deq, input logic fl);
    q.in_count = 3'(n);
    q.deq_num  = 3'(deq);
    q.flush    = fl;
    for (int i = 0; i < 4; i++) begin
      q.in_pc[i]         = base + 32'(4 * i);
      q.in_inst[i]       = ~(base + 32'(4 * i));
      q.in_pred_taken[i] = 1'(i & 1);
      q.in_pred_addr[i]  = base + 32'(4 * i) + 32'h100;
    end
    step();
    q.in_count = 3'd0;
    q.deq_num  = 3'd0;
    q.flush    = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    q.in_count = 3'd4;
    q.deq_num  = 3'd0;
    q.flush    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q.in_pc[i] = 32'hDEAD0000;
      q.in_inst[i] = '0;
      q.in_pred_taken[i] = 1'b0;
      q.in_pred_addr[i] = '0;
    end
    do_reset();
    q.in_count = 3'd0;
    chk("reset_count", 32'(q.count), 32'd0);
    chk("reset_stall", 32'(q.stall), 32'd0);
    chk("reset_valid", 32'(vld()), 32'h0);
    for (int i = 0; i < 4; i++) chk("reset_out_pc", q.out_pc[i], 32'h0);
  endtask

  task automatic test_partial();
    drive(2, 32'hBFC00000, 0, 1'b0);
    chk("partial_valid", 32'(vld()), 32'h3);
    chk("partial_count", 32'(q.count), 32'd2);
    chk("partial_pc0", q.out_pc[0], 32'hBFC00000);
    chk("partial_pc1", q.out_pc[1], 32'hBFC00004);
    chk("partial_inst1", q.out_inst[1], ~32'hBFC00004);
    chk("partial_taken1", 32'(q.out_pred_taken[1]), 32'd1);
    chk("partial_addr1", q.out_pred_addr[1], 32'hBFC00104);
    chk("partial_pc2_masked", q.out_pc[2], 32'h0);
  endtask

  task automatic test_fill();
    bit seen_dropped = 1'b0;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      drive(4, 32'h2000 + 32'(16 * b), 0, 1'b0);
      chk("fill_count", 32'(q.count), 32'(4 * (b + 1)));
      chk("fill_stall", 32'(q.stall), (b == 3) ? 32'd1 : 32'd0);
    end
    drive(4, 32'h2040, 0, 1'b0);
    chk("fill_drop_count", 32'(q.count), 32'd16);
    chk("fill_drop_stall", 32'(q.stall), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("fill_drain_pc0", q.out_pc[0], 32'h2000 + 32'(16 * k));
      chk("fill_drain_pc3", q.out_pc[3], 32'h200C + 32'(16 * k));
      for (int i = 0; i < 4; i++) if (q.out_pc[i] == 32'h2040) seen_dropped = 1'b1;
      drive(0, 32'h0, 4, 1'b0);
    end
    chk("fill_dropped_seen", 32'(seen_dropped), 32'd0);
    chk("fill_empty_count", 32'(q.count), 32'd0);
  endtask

  task automatic test_wrap();
    drive(4, 32'h1000, 0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      chk("wrap_pc0", q.out_pc[0], 32'h1000 + 32'(16 * k));
      chk("wrap_pc3", q.out_pc[3], 32'h100C + 32'(16 * k));
      drive(4, 32'h1010 + 32'(16 * k), 4, 1'b0);
      chk("wrap_count", 32'(q.count), 32'd4);
    end
    chk("wrap_last_pc0", q.out_pc[0], 32'h10C0);
    drive(0, 32'h0, 4, 1'b0);
    chk("wrap_drained", 32'(q.count), 32'd0);
  endtask

  task automatic test_mixed();
    drive(4, 32'h3000, 0, 1'b0);
    drive(1, 32'h3010, 0, 1'b0);
    chk("mixed_count5", 32'(q.count), 32'd5);
    drive(3, 32'h3014, 2, 1'b0);
    chk("mixed_count6", 32'(q.count), 32'd6);
    chk("mixed_pc0", q.out_pc[0], 32'h3008);
    drive(0, 32'h0, 4, 1'b0);
    chk("mixed_count2", 32'(q.count), 32'd2);
    chk("mixed_pc0b", q.out_pc[0], 32'h3018);
    chk("mixed_pc1b", q.out_pc[1], 32'h301C);
    if (4 > int'(q.count))
      $display("note: protocol error, deq_num=4 exceeds count=%0d", q.count);
    drive(0, 32'h0, 4, 1'b0);
    chk("mixed_clamp_count", 32'(q.count), 32'd0);
    chk("mixed_clamp_valid", 32'(vld()), 32'h0);
  endtask

  task automatic test_flush();
    drive(4, 32'h4000, 0, 1'b0);
    drive(4, 32'h4010, 0, 1'b0);
    drive(1, 32'h4020, 0, 1'b0);
    chk("flush_pre_count", 32'(q.count), 32'd9);
    drive(4, 32'h5000, 3, 1'b1);
    chk("flush_count", 32'(q.count), 32'd0);
    chk("flush_valid", 32'(vld()), 32'h0);
    chk("flush_stall", 32'(q.stall), 32'd0);
    chk("flush_pc0", q.out_pc[0], 32'h0);
    drive(0, 32'h0, 0, 1'b0);
    chk("flush_idle_count", 32'(q.count), 32'd0);
    drive(1, 32'h6000, 0, 1'b0);
    chk("flush_after_count", 32'(q.count), 32'd1);
    chk("flush_after_pc0", q.out_pc[0], 32'h6000);
    chk("flush_after_valid", 32'(vld()), 32'h1);
  endtask

  initial begin
    test_reset();
    test_partial();
    test_fill();
    test_wrap();
    test_mixed();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
